apu_seq: RTL and testbench



---
 rtl/apu_seq.sv | 141 ++++++++++++++
 tb/tb_apu_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_seq.sv
// APU instruction sequencer: fetches 32-bit instructions from the instruction RAM,
// dispatches engine commands over valid/ready and pulses cal_cpl when the program ends.
`timescale 1ns/1ps
module apu_seq #(
    parameter int IR_AW = 4,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             apu_ready,
    output logic             ir_ram_ren,
    output logic [IR_AW-1:0] ir_ram_raddr,
    input  logic [31:0]      ir_ram_rdata,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [OP_W-1:0]  cmd_op,
    output logic [27:0]      cmd_arg,
    input  logic             layer_done,
    output logic             busy,
    output logic [IR_AW-1:0] pc,
    output logic             cal_cpl
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_RD  = 3'd2,
        DECODE   = 3'd3,
        DISPATCH = 3'd4,
        EXEC     = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [IR_AW-1:0] PC_LAST = '1;

    state_t            state_q, state_d;
    logic [IR_AW-1:0]  pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [OP_W-1:0]   cmd_op_q, cmd_op_d;
    logic [27:0]       cmd_arg_q, cmd_arg_d;
    logic              rdy_prev_q;
    logic              advance;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_arg_q   <= '0;
            rdy_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_arg_q   <= cmd_arg_d;
            rdy_prev_q  <= apu_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_arg_d   = cmd_arg_q;
        advance     = 1'b0;

        // Dropping apu_ready abandons the program from any active state; pc is kept.
        if (state_q != IDLE && !apu_ready) begin
            state_d     = IDLE;
            cmd_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (apu_ready && !rdy_prev_q) begin
                        state_d = FETCH;
                        pc_d    = '0;
                    end
                end
                FETCH:   state_d = WAIT_RD;
                WAIT_RD: begin
                    instr_d = ir_ram_rdata;
                    state_d = DECODE;
                end
                DECODE: begin
                    if (instr_q[30:28] == 3'd0) begin
                        advance = 1'b1;
                    end else begin
                        state_d     = DISPATCH;
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = OP_W'(instr_q[30:28]);
                        cmd_arg_d   = instr_q[27:0];
                    end
                end
                DISPATCH: begin
                    if (cmd_valid_q && cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        if (layer_done) begin
                            advance = 1'b1;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (layer_done) begin
                        advance = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // The last RAM slot always ends the program, so pc never wraps.
        if (advance) begin
            if (instr_q[31] || pc_q == PC_LAST) begin
                state_d = DONE;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = FETCH;
            end
        end
    end

    assign ir_ram_ren   = (state_q == FETCH);
    assign ir_ram_raddr = pc_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_op       = cmd_op_q;
    assign cmd_arg      = cmd_arg_q;
    assign busy         = (state_q != IDLE);
    assign pc           = pc_q;
    assign cal_cpl      = (state_q == DONE);

endmodule

// File: tb/tb_apu_seq.sv
// Self-checking bench for apu_seq: instruction RAM model, engine responder and command scoreboard.
`timescale 1ns/1ps
module tb_apu_seq;
    localparam int IR_AW = 4;
    localparam int OP_W  = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             apu_ready;
    logic             ir_ram_ren;
    logic [IR_AW-1:0] ir_ram_raddr;
    logic [31:0]      ir_ram_rdata;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [27:0]      cmd_arg;
    logic             layer_done;
    logic             busy;
    logic [IR_AW-1:0] pc;
    logic             cal_cpl;

    logic [31:0] mem [16];
    logic [30:0] exp_q [$];
    logic [30:0] act_q [$];

    int errors = 0;
    int checks = 0;

    int cal_cnt, pc_at_cal, hold_bad, stall_seen, coincide, max_lat, n_acc;
    logic busy_after;

    apu_seq #(.IR_AW(IR_AW), .OP_W(OP_W)) dut (
        .clk(clk), .rstn(rstn), .apu_ready(apu_ready),
        .ir_ram_ren(ir_ram_ren), .ir_ram_raddr(ir_ram_raddr), .ir_ram_rdata(ir_ram_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .layer_done(layer_done), .busy(busy), .pc(pc), .cal_cpl(cal_cpl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ir_ram_ren) ir_ram_rdata <= mem[ir_ram_raddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        exp_q.delete();
        act_q.delete();
    endtask

    // Reference model: every non-NOP instruction up to END or the last slot is dispatched once.
    task automatic push_expected();
        for (int i = 0; i < 16; i++) begin
            if (mem[i][30:28] != 3'd0) exp_q.push_back(mem[i][30:0]);
            if (mem[i][31]) break;
        end
    endtask

    task automatic start_prog();
        @(negedge clk);
        apu_ready = 1'b0;
        @(negedge clk);
        apu_ready = 1'b1;
    endtask

    // Engine responder: stalls cmd_ready, answers with layer_done dly cycles after accept
    // (or in the accept cycle), optionally aborts in EXEC after the given accept count.
    task automatic run_program(input int stall, input int dly, input bit same, input int abort_after);
        int n, done_cnt, stall_left, acc_n;
        bit snap_valid, cal_seen, lat_pending;
        logic [OP_W-1:0] snap_op;
        logic [27:0]     snap_arg;
        cal_cnt = 0; pc_at_cal = -1; hold_bad = 0; stall_seen = 0; coincide = 0;
        max_lat = 0; n_acc = 0; busy_after = 1'bx;
        n = 0; done_cnt = 0; stall_left = 0; acc_n = 0;
        snap_valid = 0; cal_seen = 0; lat_pending = 0;
        snap_op = '0; snap_arg = '0;
        cmd_ready = 1'b0;
        layer_done = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (n > 600) begin
                checks++; errors++;
                $display("FAIL run_timeout: no program end after %0d cycles, required cal_cpl", n);
                break;
            end
            layer_done = 1'b0;
            cmd_ready  = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) layer_done = 1'b1;
            end
            if (lat_pending && (ir_ram_ren || cal_cpl)) begin
                if (n - acc_n > max_lat) max_lat = n - acc_n;
                lat_pending = 0;
            end
            if (cal_seen) begin
                busy_after = busy;
                break;
            end
            if (cal_cpl) begin
                cal_cnt++;
                pc_at_cal = int'(pc);
                cal_seen = 1;
                if (cmd_valid) coincide++;
            end
            if (abort_after > 0 && n_acc == abort_after && acc_n == n - 1 && done_cnt > 0) begin
                apu_ready  = 1'b0;
                layer_done = 1'b0;
                break;
            end
            if (cmd_valid) begin
                if (!snap_valid) begin
                    snap_op = cmd_op; snap_arg = cmd_arg; snap_valid = 1; stall_left = stall;
                end else if (cmd_op !== snap_op || cmd_arg !== snap_arg) begin
                    hold_bad++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    stall_seen++;
                end else begin
                    cmd_ready = 1'b1;
                    act_q.push_back({cmd_op, cmd_arg});
                    n_acc++;
                    snap_valid = 0;
                    acc_n = n;
                    lat_pending = 1;
                    if (same) layer_done = 1'b1;
                    else done_cnt = dly;
                end
            end
        end
        cmd_ready  = 1'b0;
        layer_done = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; apu_ready = 1'b0; cmd_ready = 1'b0; layer_done = 1'b0;
        ir_ram_rdata = 32'h0;
        clear_mem();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (ir_ram_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b required 0", ir_ram_ren); end
        checks++; if (ir_ram_raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d required 0", ir_ram_raddr); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b required 0", cmd_valid); end
        checks++; if (cmd_op !== 3'd0) begin errors++; $display("FAIL reset_cmd_op: got %0d required 0", cmd_op); end
        checks++; if (cmd_arg !== 28'd0) begin errors++; $display("FAIL reset_cmd_arg: got %h required 0", cmd_arg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0d required 0", pc); end
        checks++; if (cal_cpl !== 1'b0) begin errors++; $display("FAIL reset_cal_cpl: got %b required 0", cal_cpl); end
    endtask

    task automatic test_basic();
        logic [30:0] e, a;
        clear_mem();
        mem[0] = 32'h1000_0005;
        mem[1] = 32'hA000_0007;
        push_expected();
        start_prog();
        run_program(0, 4, 1'b0, 0);
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_cmd_count: got %0d required %0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL basic_cmd: got op%0d arg %h required op%0d arg %h", a[30:28], a[27:0], e[30:28], e[27:0]); end
        end
        checks++; if (cal_cnt != 1) begin errors++; $display("FAIL basic_cal_count: got %0d required 1", cal_cnt); end
        checks++; if (pc_at_cal != 1) begin errors++; $display("FAIL basic_pc: got %0d required 1", pc_at_cal); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy_after); end
        checks++; if (coincide != 0) begin errors++; $display("FAIL basic_cal_with_valid: got %0d required 0", coincide); end
        checks++; if (max_lat != 5) begin errors++; $display("FAIL basic_exec_latency: got %0d required 5", max_lat); end
    endtask

    task automatic test_backpressure();
        logic [30:0] e, a;
        clear_mem();
        mem[0] = 32'hB000_0123;
        push_expected();
        start_prog();
        run_program(5, 2, 1'b0, 0);
        checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_valid_held: got %0d cycles required 5", stall_seen); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_payload_stable: got %0d changes required 0", hold_bad); end
        checks++; if (n_acc != 1) begin errors++; $display("FAIL bp_accepts: got %0d required 1", n_acc); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_cmd_count: got %0d required %0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL bp_cmd: got op%0d arg %h required op%0d arg %h", a[30:28], a[27:0], e[30:28], e[27:0]); end
        end
        checks++; if (cal_cnt != 1) begin errors++; $display("FAIL bp_cal_count: got %0d required 1", cal_cnt); end
    endtask

    task automatic test_nop_full();
        logic [30:0] e, a;
        clear_mem();
        mem[15] = 32'h3000_0001;
        push_expected();
        start_prog();
        run_program(0, 3, 1'b0, 0);
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL nop_cmd_count: got %0d required %0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL nop_cmd: got op%0d arg %h required op%0d arg %h", a[30:28], a[27:0], e[30:28], e[27:0]); end
        end
        checks++; if (cal_cnt != 1) begin errors++; $display("FAIL nop_cal_count: got %0d required 1", cal_cnt); end
        checks++; if (pc_at_cal != 15) begin errors++; $display("FAIL nop_pc_at_cal: got %0d required 15", pc_at_cal); end
        repeat (3) @(negedge clk);
        checks++; if (pc !== 4'd15) begin errors++; $display("FAIL nop_pc_no_wrap: got %0d required 15", pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_idle_after: got busy %b required 0", busy); end
    endtask

    task automatic test_abort();
        logic [30:0] e, a;
        int bad;
        clear_mem();
        mem[0] = 32'h1000_0001;
        mem[1] = 32'h2000_0002;
        mem[2] = 32'hC000_0003;
        exp_q.push_back({3'd1, 28'd1});
        exp_q.push_back({3'd2, 28'd2});
        push_expected();
        start_prog();
        run_program(0, 4, 1'b0, 2);
        checks++; if (n_acc != 2) begin errors++; $display("FAIL abort_accepts_before: got %0d required 2", n_acc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b required 0", busy); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b required 0", cmd_valid); end
        checks++; if (pc !== 4'd1) begin errors++; $display("FAIL abort_pc_kept: got %0d required 1", pc); end
        bad = 0;
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        repeat (3) begin
            if (busy !== 1'b0 || cal_cpl !== 1'b0 || cmd_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_late_done_ignored: got %0d active cycles required 0", bad); end
        apu_ready = 1'b1;
        @(negedge clk);
        checks++; if (ir_ram_ren !== 1'b1 || ir_ram_raddr !== 4'd0 || pc !== 4'd0) begin
            errors++; $display("FAIL abort_restart: got ren %b raddr %0d pc %0d required 1 0 0", ir_ram_ren, ir_ram_raddr, pc);
        end
        run_program(0, 2, 1'b0, 0);
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_cmd_count: got %0d required %0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL abort_cmd: got op%0d arg %h required op%0d arg %h", a[30:28], a[27:0], e[30:28], e[27:0]); end
        end
        checks++; if (cal_cnt != 1 || pc_at_cal != 2) begin errors++; $display("FAIL abort_rerun_end: got cal %0d pc %0d required 1 2", cal_cnt, pc_at_cal); end
    endtask

    task automatic test_level_hold_same();
        logic [30:0] e, a;
        int bad;
        clear_mem();
        mem[0] = 32'h1000_0011;
        mem[1] = 32'h9000_0022;
        push_expected();
        start_prog();
        run_program(0, 0, 1'b1, 0);
        checks++; if (max_lat != 1) begin errors++; $display("FAIL same_cycle_done_latency: got %0d required 1", max_lat); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL same_cmd_count: got %0d required %0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL same_cmd: got op%0d arg %h required op%0d arg %h", a[30:28], a[27:0], e[30:28], e[27:0]); end
        end
        checks++; if (cal_cnt != 1) begin errors++; $display("FAIL same_cal_count: got %0d required 1", cal_cnt); end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || ir_ram_ren !== 1'b0 || cal_cpl !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL level_hold_no_restart: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_async_reset();
        int k;
        clear_mem();
        mem[1] = 32'h5000_0055;
        start_prog();
        cmd_ready = 1'b0;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++; if (cmd_valid !== 1'b1 || pc !== 4'd1) begin
            errors++; $display("FAIL arst_reach_dispatch: got valid %b pc %0d required 1 1", cmd_valid, pc);
        end
        #2 rstn = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", cmd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b required 0", busy); end
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL arst_pc: got %0d required 0", pc); end
        checks++; if (cmd_op !== 3'd0 || cmd_arg !== 28'd0) begin errors++; $display("FAIL arst_payload: got op%0d arg %h required 0 0", cmd_op, cmd_arg); end
        apu_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_nop_full();
        test_abort();
        test_level_hold_same();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
